// File: rtl/sha3_hw_seq.sv
// Hardware hash sequencer plus firmware/sequencer arbiter on the SHA3 engine valid-hold port.
// One engine access outstanding at a time; the firmware is held off (hld=1) while the sequencer owns the port.
module sha3_hw_seq #(
  parameter logic [31:0] CFG_ADDR    = 32'h14,
  parameter logic [31:0] CMD_ADDR    = 32'h18,
  parameter logic [31:0] STATUS_ADDR = 32'h1C,
  parameter logic [31:0] STATE_ADDR  = 32'h400,
  parameter logic [31:0] MSG_ADDR    = 32'h800,
  parameter int          POLL_MAX    = 1024
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start_i,
  input  logic         mode_i,
  output logic         ready_o,
  input  logic         msg_valid_i,
  output logic         msg_ready_o,
  input  logic [31:0]  msg_data_i,
  input  logic [3:0]   msg_strb_i,
  input  logic         msg_last_i,
  output logic         done_o,
  output logic         err_o,
  output logic [511:0] digest_o,
  input  logic         fw_dv_i,
  input  logic         fw_write_i,
  input  logic [31:0]  fw_addr_i,
  input  logic [31:0]  fw_wdata_i,
  input  logic [3:0]   fw_wstrb_i,
  output logic         fw_hld_o,
  output logic [31:0]  fw_rdata_o,
  output logic         fw_err_o,
  output logic         eng_dv_o,
  output logic         eng_write_o,
  output logic [31:0]  eng_addr_o,
  output logic [31:0]  eng_wdata_o,
  output logic [3:0]   eng_wstrb_o,
  input  logic         eng_hld_i,
  input  logic [31:0]  eng_rdata_i,
  input  logic         eng_err_i
);

  localparam int PW = $clog2(POLL_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG0, S_CFG1, S_START, S_MSG, S_DRAIN,
    S_PROC, S_POLL, S_READ, S_DONECMD, S_RESP
  } state_e;

  state_e         state_q, state_d;
  logic           owner_q, owner_d;   // 1 = sequencer owns the engine port
  logic           want_q, want_d;
  logic           mode_q, mode_d;
  logic           err_q, err_d;
  logic [PW-1:0]  poll_q, poll_d;
  logic [3:0]     idx_q, idx_d;
  logic [511:0]   digest_q, digest_d;

  logic           seq_dv, seq_write;
  logic [31:0]    seq_addr, seq_wdata;
  logic [3:0]     seq_wstrb;
  logic           seq_done, start_acc, grant, zero_beat;

  assign ready_o   = (state_q == S_IDLE) && !want_q;
  assign start_acc = start_i && ready_o;
  // Handover only when the firmware has no access in flight or finishes one this cycle.
  assign grant     = !owner_q && (start_acc || want_q) && (!fw_dv_i || !eng_hld_i);
  assign seq_done  = seq_dv && !eng_hld_i;
  assign zero_beat = msg_valid_i && msg_last_i && (msg_strb_i == 4'b0000);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      want_q   <= 1'b0;
      mode_q   <= 1'b0;
      err_q    <= 1'b0;
      poll_q   <= '0;
      idx_q    <= '0;
      digest_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      want_q   <= want_d;
      mode_q   <= mode_d;
      err_q    <= err_d;
      poll_q   <= poll_d;
      idx_q    <= idx_d;
      digest_q <= digest_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    want_d   = want_q;
    mode_d   = mode_q;
    err_d    = err_q;
    poll_d   = poll_q;
    idx_d    = idx_q;
    digest_d = digest_q;
    if (start_acc) begin
      mode_d   = mode_i;
      err_d    = 1'b0;
      digest_d = '0;
      want_d   = 1'b1;
    end
    case (state_q)
      S_IDLE: if (grant) begin
        owner_d = 1'b1;
        want_d  = 1'b0;
        poll_d  = '0;
        idx_d   = '0;
        state_d = S_CFG0;
      end
      S_CFG0:  if (seq_done) state_d = S_CFG1;
      S_CFG1:  if (seq_done) state_d = S_START;
      S_START: if (seq_done) state_d = S_MSG;
      S_MSG: begin
        if (zero_beat) begin
          state_d = S_PROC;
        end else if (seq_done) begin
          if (eng_err_i) begin
            err_d   = 1'b1;
            state_d = msg_last_i ? S_DONECMD : S_DRAIN;
          end else if (msg_last_i) begin
            state_d = S_PROC;
          end
        end
      end
      S_DRAIN: if (msg_valid_i && msg_last_i) state_d = S_DONECMD;
      S_PROC:  if (seq_done) state_d = S_POLL;
      S_POLL: if (seq_done) begin
        if (eng_rdata_i[2]) begin
          state_d = S_READ;
        end else begin
          poll_d = poll_q + PW'(1);
          if (poll_d == PW'(POLL_MAX)) begin
            err_d   = 1'b1;
            state_d = S_DONECMD;
          end
        end
      end
      S_READ: if (seq_done) begin
        digest_d[{idx_q, 5'd0} +: 32] = eng_rdata_i;
        if (idx_q == (mode_q ? 4'd15 : 4'd7)) state_d = S_DONECMD;
        else                                  idx_d   = idx_q + 4'd1;
      end
      S_DONECMD: if (seq_done) begin
        if (eng_err_i) err_d = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        owner_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // An engine error outside MSG/DONECMD abandons the job but still sends the done command.
    if (seq_done && eng_err_i && (state_q inside {S_CFG0, S_CFG1, S_START, S_PROC, S_POLL, S_READ})) begin
      err_d   = 1'b1;
      state_d = S_DONECMD;
    end
  end

  always_comb begin
    seq_dv      = 1'b0;
    seq_write   = 1'b1;
    seq_addr    = '0;
    seq_wdata   = '0;
    seq_wstrb   = 4'hF;
    msg_ready_o = 1'b0;
    case (state_q)
      S_CFG0, S_CFG1: begin
        seq_dv    = 1'b1;
        seq_addr  = CFG_ADDR;
        seq_wdata = mode_q ? 32'd8 : 32'd4;
      end
      S_START:   begin seq_dv = 1'b1; seq_addr = CMD_ADDR; seq_wdata = 32'h1D; end
      S_PROC:    begin seq_dv = 1'b1; seq_addr = CMD_ADDR; seq_wdata = 32'h2E; end
      S_DONECMD: begin seq_dv = 1'b1; seq_addr = CMD_ADDR; seq_wdata = 32'h16; end
      S_MSG: begin
        seq_dv      = msg_valid_i && !zero_beat;
        seq_addr    = MSG_ADDR;
        seq_wdata   = msg_data_i;
        seq_wstrb   = msg_strb_i;
        msg_ready_o = msg_valid_i && (zero_beat || !eng_hld_i);
      end
      S_DRAIN: msg_ready_o = msg_valid_i;
      S_POLL: begin
        seq_dv    = 1'b1;
        seq_write = 1'b0;
        seq_addr  = STATUS_ADDR;
        seq_wstrb = 4'h0;
      end
      S_READ: begin
        seq_dv    = 1'b1;
        seq_write = 1'b0;
        seq_addr  = STATE_ADDR + {26'd0, idx_q, 2'b00};
        seq_wstrb = 4'h0;
      end
      default: ;
    endcase
  end

  assign done_o   = (state_q == S_RESP);
  assign err_o    = done_o && err_q;
  assign digest_o = digest_q;

  assign eng_dv_o    = owner_q ? seq_dv    : fw_dv_i;
  assign eng_write_o = owner_q ? seq_write : fw_write_i;
  assign eng_addr_o  = owner_q ? seq_addr  : fw_addr_i;
  assign eng_wdata_o = owner_q ? seq_wdata : fw_wdata_i;
  assign eng_wstrb_o = owner_q ? seq_wstrb : fw_wstrb_i;
  assign fw_hld_o    = owner_q ? 1'b1  : eng_hld_i;
  assign fw_rdata_o  = owner_q ? 32'd0 : eng_rdata_i;
  assign fw_err_o    = owner_q ? 1'b0  : eng_err_i;

endmodule

// File: doc/sha3_hw_seq.md
# sha3_hw_seq

Hardware sequencer and bus arbiter in front of the SHA3 engine's valid-hold (VH) register port. It lets an internal hardware requester hash a word stream without firmware. It issues the CFG/CMD/MSG_FIFO/STATUS/STATE register accesses itself and returns the digest. It also arbitrates the same VH port with the firmware (AHB-derived) VH path, so firmware and hardware never interleave accesses to the engine.

## Interface
Parameters:
- CFG_ADDR, 32'h14: CFG_SHADOWED offset
- CMD_ADDR, 32'h18: CMD offset
- STATUS_ADDR, 32'h1C: STATUS offset
- STATE_ADDR, 32'h400: digest (STATE) base offset
- MSG_ADDR, 32'h800: MSG_FIFO offset
- POLL_MAX, 1024: maximum STATUS reads before timeout

Ports (clock and reset first):
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- start_i  in  1  request pulse; accepted only while ready_o=1
- mode_i  in  1  0=SHA3-256, 1=SHA3-512; sampled with start_i
- ready_o  out  1  sequencer idle and able to accept start_i
- msg_valid_i / msg_ready_o  in / out  1 / 1  message-beat handshake
- msg_data_i  in  32  message word
- msg_strb_i  in  4  byte strobe for the beat
- msg_last_i  in  1  final beat
- done_o  out  1  one-cycle pulse when the job ends
- err_o  out  1  job status, valid while done_o=1
- digest_o  out  512  digest; words 0..7 (256) or 0..15 (512); unused words are 0
- fw_dv_i, fw_write_i, fw_addr_i[31:0], fw_wdata_i[31:0], fw_wstrb_i[3:0]  in: firmware VH request
- fw_hld_o, fw_rdata_o[31:0], fw_err_o  out: firmware VH response
- eng_dv_o, eng_write_o, eng_addr_o[31:0], eng_wdata_o[31:0], eng_wstrb_o[3:0]  out: engine VH request
- eng_hld_i, eng_rdata_i[31:0], eng_err_i  in: engine VH response

## Operation
- VH rule: dv and its address/data stay stable while hld=1. An access completes in the cycle with dv=1 and hld=0; rdata and err are valid in that cycle.
- Arbiter: the owner register is FW or SEQ; reset value FW.
  - Ownership changes only when the current owner's dv is low, or its access completes that cycle.
  - FW owner: the fw_* request passes through to eng_*, and the engine response passes back.
  - SEQ owner: eng_* is driven by the FSM. fw_hld_o=1, fw_rdata_o=0, fw_err_o=0.
- start_i accepted (ready_o=1): latch mode_i, clear digest_o and err, request ownership. The FSM leaves IDLE once the owner is SEQ.
- FSM states:
  - IDLE
  - CFG0, CFG1: write CFG twice, because the register is shadowed. Value is kstrength<<1, with kstrength=2 for SHA3-256 and 4 for SHA3-512.
  - START: write CMD=0x1D.
  - MSG: for each beat, write MSG_ADDR with wdata=msg_data_i and wstrb=msg_strb_i. msg_ready_o pulses in the write-completion cycle. A beat with msg_last_i=1 and msg_strb_i=0 is consumed with no bus write; this supports zero-length messages.
  - PROC: write CMD=0x2E.
  - POLL: read STATUS until bit2 (squeeze)=1. Each read increments a counter; reaching POLL_MAX sets err.
  - READ: read STATE_ADDR+4*i for i=0..7 or 0..15 into digest word i.
  - DONECMD: write CMD=0x16.
  - RESP: pulse done_o, release ownership, return to IDLE.
- Error handling: eng_err_i on any completed SEQ access, or a poll timeout, sets err and jumps to DONECMD. If the error occurs in MSG, the remaining beats up to and including msg_last_i are drained (msg_ready_o=1, no bus writes) before DONECMD. The DONECMD write is always issued, even if it errors, and err_o=1 is reported in RESP.
- Only one access is outstanding at a time. A new SEQ access is issued the cycle after the previous one completes.

## Timing
- Reset values: ready_o=1, msg_ready_o=0, done_o=0, err_o=0, digest_o=0, eng_dv_o=0, fw_hld_o=0, FSM=IDLE, owner=FW.
- start_i to the first eng_dv_o: 1 cycle if FW is idle. Otherwise wait for the current FW access to complete, then 1 cycle.
- A zero-wait engine gives 1 cycle per access. Minimum SHA3-256 job with N message writes: 2+1+N+1+1+8+1 accesses, plus 1 RESP cycle.
- ready_o is 0 from the cycle after start acceptance through RESP. It is 1 again in the cycle after done_o.
- start_i while ready_o=0 is ignored.
- start_i in the same cycle that fw_dv_i rises: FW wins that access, SEQ takes the next gap.
- Asynchronous reset mid-job returns all state to reset values immediately. The engine is not cleaned up; firmware must reset it.

## Test plan
- SHA3-256 of "abc" (one beat 0x00636261, strb 4'b0111, last) -> CFG written 0x4 twice, CMD 0x1D/0x2E/0x16; digest words 0..7 = 0x3a985da7... per engine; err_o=0.
- SHA3-512 zero-length (last, strb=0) -> no MSG_FIFO write; 16 STATE reads; digest_o[511:0] = SHA3-512("").
- FW access mid-job -> fw_hld_o held at 1 until RESP, then the FW access completes with correct rdata. FW busy with hld at start_i -> SEQ waits for completion.
- eng_err_i on the 2nd MSG write of 4 beats -> remaining beats drained, DONECMD issued, done_o with err_o=1.
- STATUS bit2 never set, POLL_MAX=4 -> exactly 4 STATUS reads, then DONECMD, err_o=1.
- reset_n low during READ -> all outputs at reset values the same cycle; a following job completes correctly.
